// File: rtl/uart_echo_tester.sv
// uart_echo_tester: stop-and-wait UART echo checker, with the uart block it drives.
// Sends seed+i, expects each byte back unchanged, counts mismatches and timeouts.
module uart_fifo #(parameter int W = 8, parameter int A = 2) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd,
  input  logic         wr,
  input  logic [W-1:0] w_data,
  output logic         empty,
  output logic         full,
  output logic [W-1:0] r_data
);
  logic [W-1:0] mem [2**A];
  logic [A:0] wp, rp;
  assign empty = wp == rp;
  assign full = wp == {~rp[A], rp[A-1:0]};
  assign r_data = mem[rp[A-1:0]];
  always_ff @(posedge clk) if (wr && !full) mem[wp[A-1:0]] <= w_data;
  always_ff @(posedge clk, posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr && !full) wp <= wp + (A+1)'(1);
      if (rd && !empty) rp <= rp + (A+1)'(1);
    end
endmodule

module uart_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       tick,
  output logic       done,
  output logic [7:0] data
);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  rx_state_t st;
  logic [3:0] s;
  logic [2:0] n;
  logic [1:0] sync;
  always_ff @(posedge clk, posedge reset)
    if (reset) begin
      st <= R_IDLE;
      s <= '0;
      n <= '0;
      data <= '0;
      done <= 1'b0;
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
      done <= 1'b0;
      case (st)
        R_IDLE: if (!sync[1]) begin st <= R_START; s <= '0; end
        R_START: if (tick) begin
          if (s == 4'd7) begin st <= R_DATA; s <= '0; n <= '0; end
          else s <= s + 4'd1;
        end
        R_DATA: if (tick) begin
          if (s == 4'd15) begin
            s <= '0;
            data <= {sync[1], data[7:1]};
            if (n == 3'd7) st <= R_STOP;
            else n <= n + 3'd1;
          end else s <= s + 4'd1;
        end
        R_STOP: if (tick) begin
          if (s == 4'd15) begin st <= R_IDLE; done <= 1'b1; end
          else s <= s + 4'd1;
        end
      endcase
    end
endmodule

module uart_tx (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       tick,
  input  logic [7:0] din,
  output logic       take,
  output logic       tx
);
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
  tx_state_t st;
  logic [3:0] s;
  logic [2:0] n;
  logic [7:0] b;
  assign take = start && st == T_IDLE;
  always_ff @(posedge clk, posedge reset)
    if (reset) begin
      st <= T_IDLE;
      s <= '0;
      n <= '0;
      b <= '0;
      tx <= 1'b1;
    end else
      case (st)
        T_IDLE: if (start) begin st <= T_START; s <= '0; b <= din; tx <= 1'b0; end
        T_START: if (tick) begin
          if (s == 4'd15) begin st <= T_DATA; s <= '0; n <= '0; tx <= b[0]; end
          else s <= s + 4'd1;
        end
        T_DATA: if (tick) begin
          if (s == 4'd15) begin
            s <= '0;
            b <= b >> 1;
            tx <= n == 3'd7 ? 1'b1 : b[1];
            if (n == 3'd7) st <= T_STOP;
            else n <= n + 3'd1;
          end else s <= s + 4'd1;
        end
        T_STOP: if (tick) begin
          if (s == 4'd15) st <= T_IDLE;
          else s <= s + 4'd1;
        end
      endcase
endmodule

module uart #(parameter int ADDR_WIDTH = 2) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_uart,
  input  logic        wr_uart,
  input  logic        rx,
  input  logic [7:0]  w_data,
  input  logic [10:0] dvsr,
  output logic        tx_full,
  output logic        rx_empty,
  output logic        tx,
  output logic [7:0]  r_data
);
  logic [10:0] bc;
  logic tick, rx_done, rx_full, tx_empty, tx_take;
  logic [7:0] rx_byte, tx_byte;
  assign tick = bc == dvsr;
  always_ff @(posedge clk, posedge reset)
    if (reset) bc <= '0;
    else bc <= tick ? '0 : bc + 11'd1;
  uart_rx u_rx (.clk, .reset, .rx, .tick, .done(rx_done), .data(rx_byte));
  // An overrun drops the incoming byte rather than corrupting queued ones.
  uart_fifo #(.W(8), .A(ADDR_WIDTH)) u_rx_fifo (.clk, .reset, .rd(rd_uart), .wr(rx_done && !rx_full),
    .w_data(rx_byte), .empty(rx_empty), .full(rx_full), .r_data);
  uart_fifo #(.W(8), .A(ADDR_WIDTH)) u_tx_fifo (.clk, .reset, .rd(tx_take), .wr(wr_uart),
    .w_data, .empty(tx_empty), .full(tx_full), .r_data(tx_byte));
  uart_tx u_tx (.clk, .reset, .start(!tx_empty), .tick, .din(tx_byte), .take(tx_take), .tx);
endmodule

module uart_echo_tester #(
  parameter int NUM_BYTES = 16,
  parameter int TIMEOUT_CYCLES = 250000,
  parameter int DVSR = 651
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] seed,
  input  logic       rx,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] last_sent,
  output logic [7:0] last_recv
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, FLUSH, SEND, WAIT, CHECK, NEXT, DONE} state_t;
  state_t state;
  logic [7:0] seed_r, index, w_data, r_data, err_inc;
  logic [TW-1:0] timer;
  logic rd_uart, wr_uart, rx_empty, tx_full;
  assign err_inc = err_count + {7'd0, err_count != 8'hFF};
  assign pass = done && err_count == 8'd0;
  uart #(.ADDR_WIDTH(2)) u_uart (.clk, .reset, .rd_uart, .wr_uart, .rx, .w_data,
    .dvsr(11'(DVSR)), .tx_full, .rx_empty, .tx, .r_data);
  always_ff @(posedge clk, posedge reset)
    if (reset) begin
      state <= IDLE;
      seed_r <= '0;
      index <= '0;
      w_data <= '0;
      timer <= '0;
      rd_uart <= 1'b0;
      wr_uart <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err_count <= '0;
      last_sent <= '0;
      last_recv <= '0;
    end else begin
      rd_uart <= 1'b0;
      wr_uart <= 1'b0;
      case (state)
        IDLE: if (start) begin
          seed_r <= seed;
          err_count <= '0;
          done <= 1'b0;
          index <= '0;
          busy <= 1'b1;
          state <= FLUSH;
        end
        // Let a pending pop land before looking at rx_empty again.
        FLUSH: if (!rd_uart) begin
          if (!rx_empty) rd_uart <= 1'b1;
          else state <= SEND;
        end
        SEND: if (!tx_full) begin
          w_data <= seed_r + index;
          last_sent <= seed_r + index;
          wr_uart <= 1'b1;
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + TW'(1);
          if (timer == TW'(TIMEOUT_CYCLES - 1)) begin err_count <= err_inc; state <= NEXT; end
          else if (!rx_empty) state <= CHECK;
        end
        CHECK: begin
          last_recv <= r_data;
          rd_uart <= 1'b1;
          if (r_data != last_sent) err_count <= err_inc;
          state <= NEXT;
        end
        NEXT: if (index == 8'(NUM_BYTES - 1)) state <= DONE;
        else begin
          index <= index + 8'd1;
          state <= FLUSH;
        end
        DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_echo_tester.sv
// tb_uart_echo_tester: random runs against a behavioural far-end echo, scoreboarded per run.
module tb_uart_echo_tester;
  localparam int BIT = 64, N = 4, TMO = 2000, LATE = 2600;
  localparam int M_OK = 0, M_BAD = 1, M_DROP = 2, M_LATE = 3;
  typedef struct { logic [7:0] err, ls, lr; } exp_t;
  typedef struct { logic [7:0] b; int rel; } echo_t;
  logic clk = 0, reset = 1, start = 0, start_t = 0, loop = 0, rx_drv = 1;
  logic [7:0] seed = 0, seed_t = 0;
  logic rx, tx, busy, done, pass, tx_t, busy_t, done_t, pass_t;
  logic [7:0] err_count, last_sent, last_recv, err_t, ls_t, lr_t, m_lr = 0;
  int checks = 0, errors = 0, cyc = 0, epoch = 0, bidx = 0;
  int mode [N];
  logic [7:0] mask [N];
  exp_t exp_q[$], expt_q[$];
  logic [7:0] tx_q[$];
  echo_t echo_q[$];
  assign rx = loop ? tx : rx_drv;
  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  uart_echo_tester #(.NUM_BYTES(N), .TIMEOUT_CYCLES(TMO), .DVSR(3)) dut (.clk(clk), .reset(reset),
    .start(start), .seed(seed), .rx(rx), .tx(tx), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .last_sent(last_sent), .last_recv(last_recv));
  uart_echo_tester #(.NUM_BYTES(3), .TIMEOUT_CYCLES(1000), .DVSR(3)) dut_t (.clk(clk), .reset(reset),
    .start(start_t), .seed(seed_t), .rx(1'b1), .tx(tx_t), .busy(busy_t), .done(done_t), .pass(pass_t),
    .err_count(err_t), .last_sent(ls_t), .last_recv(lr_t));

  function automatic void cmp(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, got, want);
    end
  endfunction

  // Scoreboard monitors: one expected report per completed run.
  initial begin : mon
    logic dq;
    exp_t e;
    dq = 0;
    forever begin
      @(negedge clk);
      if (done && !dq) begin
        if (exp_q.size() == 0) cmp("run_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          cmp("err_count", err_count, e.err);
          cmp("pass", pass, e.err == 0);
          cmp("last_sent", last_sent, e.ls);
          cmp("last_recv", last_recv, e.lr);
          cmp("busy_at_done", busy, 0);
        end
      end
      dq = done;
    end
  end
  initial begin : mon_t
    logic dq;
    exp_t e;
    dq = 0;
    forever begin
      @(negedge clk);
      if (done_t && !dq) begin
        if (expt_q.size() == 0) cmp("t_run_unexpected", 1, 0);
        else begin
          e = expt_q.pop_front();
          cmp("t_err_count", err_t, e.err);
          cmp("t_pass", pass_t, 0);
          cmp("t_last_sent", ls_t, e.ls);
          cmp("t_last_recv", lr_t, e.lr);
          cmp("t_busy_at_done", busy_t, 0);
        end
      end
      dq = done_t;
    end
  end

  // Far end: deserialise tx, check order, then echo per the plan for that byte.
  initial begin : far_rx
    logic [7:0] b;
    int ep, k;
    forever begin
      do @(negedge clk); while (!(tx === 1'b0 && !reset));
      ep = epoch;
      repeat (BIT / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        b[i] = tx;
      end
      repeat (BIT) @(negedge clk);
      if (ep == epoch) begin
        if (tx_q.size() == 0) cmp("tx_extra", b, 0);
        else cmp("tx_byte", b, tx_q.pop_front());
        k = bidx;
        bidx++;
        if (!loop && k < N) begin
          if (mode[k] == M_OK) echo_q.push_back('{b, cyc});
          else if (mode[k] == M_BAD) echo_q.push_back('{b ^ mask[k], cyc});
          else if (mode[k] == M_LATE) echo_q.push_back('{b, cyc + LATE});
        end
      end
    end
  end
  initial begin : far_tx
    echo_t e;
    forever begin
      do @(negedge clk); while (!(echo_q.size() > 0 && cyc >= echo_q[0].rel));
      e = echo_q.pop_front();
      rx_drv = 0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        rx_drv = e.b[i];
        repeat (BIT) @(negedge clk);
      end
      rx_drv = 1;
      repeat (BIT) @(negedge clk);
    end
  end

  task automatic set_modes(input int a, input int b, input int c, input int d);
    mode[0] = a; mode[1] = b; mode[2] = c; mode[3] = d;
  endtask

  task automatic go(input logic [7:0] s);
    @(negedge clk);
    seed = s;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int lim, input string n);
    int c;
    c = 0;
    while (!done && c < lim) begin
      @(negedge clk);
      c++;
    end
    cmp(n, done, 1);
  endtask

  // Reference: each byte either comes back intact, altered, or not in time.
  task automatic run(input logic [7:0] s, input logic lp, input logic poke);
    exp_t e;
    logic [7:0] b;
    int err;
    err = 0;
    for (int i = 0; i < N; i++) begin
      b = s + 8'(i);
      tx_q.push_back(b);
      if (lp || mode[i] == M_OK) m_lr = b;
      else if (mode[i] == M_BAD) begin
        m_lr = b ^ mask[i];
        err++;
      end else err++;
    end
    e.err = 8'(err);
    e.ls = s + 8'(N - 1);
    e.lr = m_lr;
    exp_q.push_back(e);
    loop = lp;
    bidx = 0;
    go(s);
    if (poke) begin
      repeat (300) @(negedge clk);
      seed = ~s;
      start = 1;
      @(negedge clk);
      start = 0;
    end
    wait_done(N * (TMO + 30 * BIT), "done_run");
  endtask

  initial begin
    int r;
    repeat (3) @(negedge clk);
    cmp("rst_busy", busy, 0);
    cmp("rst_done", done, 0);
    cmp("rst_pass", pass, 0);
    cmp("rst_err", err_count, 0);
    cmp("rst_last_sent", last_sent, 0);
    cmp("rst_last_recv", last_recv, 0);
    cmp("rst_tx_idle", tx, 1);
    reset = 0;
    repeat (3) @(negedge clk);
    set_modes(M_OK, M_OK, M_OK, M_OK);
    run(8'h41, 1, 0);
    run(8'hFE, 0, 0);
    set_modes(M_OK, M_BAD, M_OK, M_OK);
    mask[1] = 8'h01;
    run(8'h10, 0, 0);
    set_modes(M_OK, M_OK, M_OK, M_LATE);
    run(8'($urandom), 0, 0);
    repeat (3000) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 9);
        mode[i] = r < 7 ? M_OK : r < 9 ? M_BAD : M_DROP;
        mask[i] = 8'($urandom_range(1, 255));
      end
      run(8'($urandom), 0, k == 0);
    end
    set_modes(M_OK, M_OK, M_OK, M_OK);
    loop = 0;
    bidx = 0;
    go(8'h5A);
    for (int c = 0; c < 100 && tx !== 1'b0; c++) @(negedge clk);
    repeat (100) @(negedge clk);
    cmp("busy_mid_run", busy, 1);
    reset = 1;
    #1;
    cmp("abort_busy", busy, 0);
    cmp("abort_done", done, 0);
    cmp("abort_pass", pass, 0);
    cmp("abort_err", err_count, 0);
    cmp("abort_last_sent", last_sent, 0);
    cmp("abort_last_recv", last_recv, 0);
    epoch++;
    tx_q.delete();
    echo_q.delete();
    m_lr = 0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    reset = 0;
    start = 0;
    repeat (5) @(negedge clk);
    cmp("start_during_reset", busy, 0);
    repeat (3000) @(negedge clk);
    run(8'h33, 0, 0);
    expt_q.push_back('{8'd3, 8'hC2, 8'h00});
    @(negedge clk);
    seed_t = 8'hC0;
    start_t = 1;
    @(negedge clk);
    start_t = 0;
    for (int c = 0; c < 3 * (1000 + 10 * BIT) && !done_t; c++) @(negedge clk);
    cmp("t_done_in_time", done_t, 1);
    repeat (20) @(negedge clk);
    cmp("t_tx_idle", tx_t, 1);
    cmp("exp_left", exp_q.size() + expt_q.size(), 0);
    cmp("tx_left", tx_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
